// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: widths, reset PC, NOP and the fetch-buffer entry.
package mips_pkg;

    localparam int          WORD_W       = 32;
    localparam int          ADDR_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] ins;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: small synchronous FIFO with flush and a registered head entry,
// so the pushed word is visible on the output one cycle after the push.
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             valid_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     head_q, head_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    logic             do_push, do_pop;

    function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & valid_q & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The entry being written this cycle may itself become the new head.
            if (count_d != '0)
                head_d = (do_push && wr_ptr_q == rd_ptr_d) ? data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            head_q   <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// MIPS32 instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// drops responses made stale by redirects and buffers live ones for IF/ID.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 3,
    parameter int          CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_ins,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    localparam int               DROP_W  = 8;
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              i_redirect_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fire;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    // Buffered plus live in-flight words may never exceed the buffer size.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
    assign o_imem_req  = ~i_redirect_q & (credit_used < DEPTH_L);
    assign o_imem_addr = pc_q;
    assign fire        = o_imem_req & i_imem_gnt;

    assign push           = i_imem_rvalid & (drop_q == '0) & ~i_redirect;
    assign push_entry.ins = i_imem_rdata;
    // Live fetches are contiguous and end at pc-4.
    assign push_entry.pc  = pc_q - 32'({outst_q, 2'b00});

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (fire) pc_d = pc_q + 32'd4;
        if (i_imem_rvalid) begin
            if (drop_q != '0) drop_d  = drop_q - 1'b1;
            else              outst_d = outst_q - 1'b1;
        end
        if (fire) outst_d = outst_d + 1'b1;
        // Every live fetch still in flight after this edge becomes stale.
        if (i_redirect) begin
            pc_d    = {i_redirect_pc[31:2], 2'b00};
            drop_d  = drop_d + DROP_W'(outst_d);
            outst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            outst_q      <= '0;
            drop_q       <= '0;
            i_redirect_q <= 1'b1;  // keeps the request low for the first cycle out of reset
        end else begin
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            i_redirect_q <= i_redirect;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (i_ready),
        .flush_i (i_redirect),
        .valid_o (o_valid),
        .head_o  (head),
        .count_o (fifo_count)
    );

    assign o_ins = head.ins;
    assign o_pc  = head.pc;
    assign o_pc4 = head.pc + 32'd4;

    a_rvalid_has_fetch: assert property (@(posedge clk) disable iff (!rst_n)
        i_imem_rvalid |-> (outst_q != '0 || drop_q != '0))
        else $error("ifetch: imem rvalid with no fetch outstanding");

endmodule

// File: tb/tb_ifetch.sv
// Directed and randomized bench for ifetch with an in-order, variable-latency memory model.
module tb_ifetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] ins, pc, pc4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (3),
        .CNT_W    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_ins         (ins),
        .o_pc          (pc),
        .o_pc4         (pc4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C1D_0000;
    endfunction

    // Memory model: grants at gnt_pct while budget remains, answers in order after lat cycles.
    int          gnt_budget = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          grants = 0;
    int          cyc = 0;
    int          last_due = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int due;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            last_due = 0;
        end else begin
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (gnt_budget > 0 && $urandom_range(99, 0) < gnt_pct) begin
                imem_gnt = 1'b1;
                if (imem_req) begin
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    q_addr.push_back(imem_addr);
                    q_due.push_back(due);
                    gnt_budget--;
                    grants++;
                end
            end
        end
    end

    // Reference model of the delivered stream: sequential from the last redirect target.
    logic [31:0] exp_pc = 32'h0;
    int          xfers = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else begin
            if (valid && ready) begin
                tests++;
                assert (pc === exp_pc && ins === mem_word(exp_pc) && pc4 === exp_pc + 32'd4)
                else begin
                    fails++;
                    $error("FAIL stream: pc=%h ins=%h pc4=%h required pc=%h ins=%h pc4=%h",
                           pc, ins, pc4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the next transfer and checks it against the expected PC.
    task automatic wait_xfer(input string tag, input logic [31:0] want_pc);
        int n;
        n = 0;
        while (!(valid && ready) && n < 40) begin
            tick(1);
            n++;
        end
        check32({tag, "_seen"}, {31'h0, valid}, 32'h1);
        check32({tag, "_pc"}, pc, want_pc);
        check32({tag, "_ins"}, ins, mem_word(want_pc));
        check32({tag, "_pc4"}, pc4, want_pc + 32'd4);
        $display("[TB] %s xfer pc=%h ins=%h pc4=%h", tag, pc, ins, pc4);
        tick(1);
    endtask

    initial begin
        int g0;
        int x0;

        // 1: reset values, then streaming at one instruction per cycle
        gnt_budget = 1000000; gnt_pct = 100; lat_min = 1; lat_max = 1; ready = 1'b1;
        rst_n = 1'b0;
        tick(2);
        check32("rst_valid", {31'h0, valid}, 32'h0);
        check32("rst_req", {31'h0, imem_req}, 32'h0);
        check32("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        tick(1);
        check32("t1_req", {31'h0, imem_req}, 32'h1);
        check32("t1_addr0", imem_addr, 32'h0);
        tick(1);
        check32("t1_addr1", imem_addr, 32'h4);
        tick(1);
        check32("t1_addr2", imem_addr, 32'h8);
        check32("t1_valid", {31'h0, valid}, 32'h1);
        check32("t1_pc0", pc, 32'h0);
        check32("t1_ins0", ins, mem_word(32'h0));
        check32("t1_pc4_0", pc4, 32'h4);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check32("t1_stream_valid", {31'h0, valid}, 32'h1);
            check32("t1_stream_pc", pc, 32'(4 * k));
            $display("[TB] t1 xfer pc=%h ins=%h", pc, ins);
        end

        // 2: back-pressure fills the buffer after exactly DEPTH fetches
        ready = 1'b0;
        do_reset();
        g0 = grants;
        tick(12);
        check32("t2_grants", 32'(grants - g0), 32'd3);
        check32("t2_req_low", {31'h0, imem_req}, 32'h0);
        check32("t2_valid", {31'h0, valid}, 32'h1);
        check32("t2_pc_hold", pc, 32'h0);
        ready = 1'b1;
        wait_xfer("t2_a", 32'h0);
        wait_xfer("t2_b", 32'h4);
        wait_xfer("t2_c", 32'h8);
        wait_xfer("t2_d", 32'hC);

        // 3: redirect with two fetches in flight
        lat_min = 4; lat_max = 4; gnt_budget = 0;
        do_reset();
        gnt_budget = 2;
        tick(3);
        check32("t3_outstanding", 32'(q_addr.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick(1);
        redirect = 1'b0;
        gnt_budget = 1000000;
        check32("t3_req_low", {31'h0, imem_req}, 32'h0);
        check32("t3_addr_tgt", imem_addr, 32'h100);
        check32("t3_flushed", {31'h0, valid}, 32'h0);
        tick(1);
        check32("t3_req_back", {31'h0, imem_req}, 32'h1);
        wait_xfer("t3_a", 32'h100);
        wait_xfer("t3_b", 32'h104);

        // 4: grant withheld, then redirect while waiting
        lat_min = 1; lat_max = 1; gnt_budget = 0;
        do_reset();
        tick(1);
        for (int k = 0; k < 5; k++) begin
            check32("t4_req_wait", {31'h0, imem_req}, 32'h1);
            check32("t4_addr_hold", imem_addr, 32'h0);
            tick(1);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect = 1'b0;
        check32("t4_req_low", {31'h0, imem_req}, 32'h0);
        tick(1);
        check32("t4_req_tgt", {31'h0, imem_req}, 32'h1);
        check32("t4_addr_tgt", imem_addr, 32'h200);
        gnt_budget = 1000000;
        wait_xfer("t4_a", 32'h200);

        // 5: PC wraps at 2^32 (redirect also hits a grant in the same cycle)
        do_reset();
        tick(1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick(1);
        redirect = 1'b0;
        check32("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(1);
        check32("t5_req_top", {31'h0, imem_req}, 32'h1);
        tick(1);
        check32("t5_addr_wrap", imem_addr, 32'h0);
        wait_xfer("t5_top", 32'hFFFF_FFFC);
        wait_xfer("t5_zero", 32'h0);

        // 6: random grants, latencies, back-pressure and redirects
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        x0 = xfers;
        for (int i = 0; i < 4000; i++) begin
            ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 3) begin
                redirect    = 1'b1;
                redirect_pc = $urandom();
            end else begin
                redirect = 1'b0;
            end
            tick(1);
        end
        redirect = 1'b0;
        ready    = 1'b1;
        tick(30);
        tests++;
        assert (xfers - x0 > 500)
        else begin
            fails++;
            $error("FAIL t6_progress: got %0d transfers required more than 500", xfers - x0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
